kb_command_scheduler: RTL and testbench

KB_COMMAND_SCHEDULER -- requirements
Module: kb_command_scheduler

---
 rtl/kb_command_scheduler.sv | 156 +++++++++++++++
 tb/tb_kb_command_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/kb_command_scheduler.sv
// rtl/kb_command_scheduler.sv - key-event to command FIFO scheduler with movement auto-repeat
// Rises and repeat ticks mark keys pending; one pending key per cycle is queued into a 4-deep FIFO.
module kb_command_scheduler #(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       w,
  input  logic       a,
  input  logic       s,
  input  logic       d,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       space,
  input  logic       enter,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  input  logic       cmd_ready,
  output logic [2:0] fifo_count,
  output logic       coalesced
);

  localparam logic [25:0] DELAY_LAST  = 26'(REPEAT_DELAY - 1);
  localparam logic [25:0] PERIOD_LAST = 26'(REPEAT_PERIOD - 1);

  // Key vector bit i carries command code i+1; orders list bit indices, highest priority first.
  localparam logic [3:0] GRANT_ORDER [10] = '{4'd9, 4'd8, 4'd6, 4'd7, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3};
  localparam logic [3:0] MOVE_ORDER  [8]  = '{4'd6, 4'd7, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3};

  logic [9:0]  keys;
  logic [9:0]  prev;
  logic [9:0]  rise;
  logic [9:0]  pending;
  logic [9:0]  set_vec;
  logic [9:0]  tick_vec;
  logic [9:0]  grant_vec;
  logic [3:0]  target_idx;
  logic [3:0]  target_code;
  logic [3:0]  last_code;
  logic [3:0]  grant_idx;
  logic [3:0]  grant_code;
  logic        target_hit;
  logic        grant_hit;
  logic        same_target;
  logic        tick;
  logic        phase_periodic;
  logic        pop;
  logic        push;
  logic        can_push;
  logic [25:0] hold_cnt;
  logic [3:0]  mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;

  assign keys = {enter, space, down, up, right, left, d, s, a, w};
  assign rise = keys & ~prev;

  always_comb begin
    target_hit = 1'b0;
    target_idx = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (keys[MOVE_ORDER[i]]) begin
        target_hit = 1'b1;
        target_idx = MOVE_ORDER[i];
      end
    end
  end

  assign target_code = target_hit ? (target_idx + 4'd1) : 4'd0;
  assign same_target = target_hit && (target_code == last_code);
  assign tick        = same_target &&
                       (phase_periodic ? (hold_cnt == PERIOD_LAST) : (hold_cnt == DELAY_LAST));
  assign tick_vec    = tick ? (10'd1 << target_idx) : 10'd0;
  assign set_vec     = rise | tick_vec;

  assign cmd_valid = (fifo_count != 3'd0);
  assign cmd_code  = cmd_valid ? mem[rd_ptr] : 4'd0;
  assign pop       = cmd_valid & cmd_ready;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign can_push  = (fifo_count != 3'd4) || pop;

  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (pending[GRANT_ORDER[i]]) begin
        grant_hit = can_push;
        grant_idx = GRANT_ORDER[i];
      end
    end
  end

  assign push       = grant_hit;
  assign grant_vec  = grant_hit ? (10'd1 << grant_idx) : 10'd0;
  assign grant_code = grant_idx + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev      <= 10'd0;
      pending   <= 10'd0;
      coalesced <= 1'b0;
    end else begin
      prev      <= keys;
      pending   <= (pending & ~grant_vec) | set_vec;
      if ((set_vec & pending & ~grant_vec) != 10'd0)
        coalesced <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr     <= 2'd0;
      wr_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= grant_code;
  end

  // The hold counter restarts whenever the repeat target changes or disappears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_code      <= 4'd0;
      hold_cnt       <= 26'd0;
      phase_periodic <= 1'b0;
    end else begin
      last_code <= target_code;
      if (!same_target) begin
        hold_cnt       <= 26'd0;
        phase_periodic <= 1'b0;
      end else if (tick) begin
        hold_cnt       <= 26'd0;
        phase_periodic <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 26'd1;
      end
    end
  end

endmodule

// File: tb/tb_kb_command_scheduler.sv
// tb/tb_kb_command_scheduler.sv - randomized and directed bench with a key-event reference model
module tb_kb_command_scheduler;

  localparam int DLY = 8;
  localparam int PER = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] kv = 10'd0;
  logic       rdy = 1'b0;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic [2:0] fifo_count;
  logic       coalesced;

  int n_checks = 0;
  int n_pass = 0;
  int deliv [16];
  int grant_prio [10] = '{10, 9, 7, 8, 5, 6, 1, 2, 3, 4};
  int move_prio [8] = '{7, 8, 5, 6, 1, 2, 3, 4};

  logic [9:0] m_prev;
  logic [9:0] m_pend;
  int         m_q [$];
  bit         m_coal;
  int         m_last;
  int         m_age;

  kb_command_scheduler #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .clock(clock), .reset(reset),
    .w(kv[0]), .a(kv[1]), .s(kv[2]), .d(kv[3]), .left(kv[4]),
    .right(kv[5]), .up(kv[6]), .down(kv[7]), .space(kv[8]), .enter(kv[9]),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(rdy),
    .fifo_count(fifo_count), .coalesced(coalesced)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_prev = 10'd0;
    m_pend = 10'd0;
    m_q.delete();
    m_coal = 1'b0;
    m_last = 0;
    m_age = 0;
  endtask

  task automatic check_outputs();
    check("valid", cmd_valid, (m_q.size() != 0));
    check("code", cmd_code, (m_q.size() != 0) ? m_q[0] : 0);
    check("count", fifo_count, m_q.size());
    check("coalesced", coalesced, m_coal);
  endtask

  // One clock: model decides from current inputs, then the DUT is compared just after the edge.
  task automatic cycle();
    int         tgt;
    int         g;
    bit         tk;
    bit         pp;
    logic [9:0] setv;
    logic [9:0] clr;
    tgt = 0;
    g = 0;
    tk = 1'b0;
    if (cmd_valid && rdy) deliv[cmd_code]++;
    foreach (move_prio[i]) if (tgt == 0 && kv[move_prio[i] - 1]) tgt = move_prio[i];
    if (tgt != 0 && tgt == m_last) begin
      m_age++;
      tk = (m_age == DLY) || (m_age > DLY && ((m_age - DLY) % PER) == 0);
    end else begin
      m_age = 0;
    end
    m_last = tgt;
    setv = kv & ~m_prev;
    if (tk) setv[tgt - 1] = 1'b1;
    pp = (m_q.size() != 0) && rdy;
    if (m_q.size() < 4 || pp)
      foreach (grant_prio[i]) if (g == 0 && m_pend[grant_prio[i] - 1]) g = grant_prio[i];
    clr = 10'd0;
    if (g != 0) clr[g - 1] = 1'b1;
    if ((setv & m_pend & ~clr) != 10'd0) m_coal = 1'b1;
    m_pend = (m_pend & ~clr) | setv;
    if (pp) void'(m_q.pop_front());
    if (g != 0) m_q.push_back(g);
    m_prev = kv;
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  // Called just after an edge; outputs must clear before any further edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_code", cmd_code, 0);
    check("rst_coal", coalesced, 0);
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic tap(input int idx);
    kv = 10'd0;
    kv[idx] = 1'b1;
    cycle();
    kv = 10'd0;
  endtask

  initial begin
    model_clear();
    foreach (deliv[i]) deliv[i] = 0;
    #2;
    check("init_valid", cmd_valid, 0);
    check("init_count", fifo_count, 0);
    check("init_code", cmd_code, 0);
    check("init_coal", coalesced, 0);
    @(posedge clock);
    #1;
    do_reset();

    // single tap of space, consumer always ready
    rdy = 1'b1;
    foreach (deliv[i]) deliv[i] = 0;
    kv = 10'd0;
    kv[8] = 1'b1;
    cycle();
    check("tap_lat1", cmd_valid, 0);
    cycle();
    check("tap_lat2_valid", cmd_valid, 1);
    check("tap_lat2_code", cmd_code, 9);
    cycle();
    kv = 10'd0;
    repeat (4) cycle();
    check("tap_deliv9", deliv[9], 1);

    // simultaneous rises with consumer stalled, then reset mid-stream
    do_reset();
    rdy = 1'b0;
    kv = 10'd0;
    kv[0] = 1'b1;
    kv[6] = 1'b1;
    kv[9] = 1'b1;
    cycle();
    kv = 10'd0;
    repeat (3) cycle();
    check("sim_count", fifo_count, 3);
    check("sim_head", cmd_code, 10);
    do_reset();

    // fill FIFO with a fifth key left pending, then one pop
    rdy = 1'b0;
    tap(0);
    tap(1);
    tap(2);
    tap(3);
    tap(6);
    repeat (3) cycle();
    check("full_count", fifo_count, 4);
    rdy = 1'b1;
    cycle();
    rdy = 1'b0;
    check("full_pop_count", fifo_count, 4);
    check("full_pop_head", cmd_code, 2);
    repeat (2) cycle();

    // coalescing: d tapped twice while FIFO is full
    do_reset();
    rdy = 1'b0;
    tap(0);
    tap(1);
    tap(2);
    tap(6);
    repeat (2) cycle();
    tap(3);
    cycle();
    tap(3);
    cycle();
    check("coal_flag", coalesced, 1);
    rdy = 1'b1;
    foreach (deliv[i]) deliv[i] = 0;
    repeat (10) cycle();
    check("coal_deliv4", deliv[4], 1);

    // auto-repeat of a held movement key
    do_reset();
    rdy = 1'b1;
    foreach (deliv[i]) deliv[i] = 0;
    kv = 10'd0;
    kv[4] = 1'b1;
    repeat (20) cycle();
    kv = 10'd0;
    repeat (6) cycle();
    check("rep_deliv5", deliv[5], 5);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:       kv = 10'($urandom);
        1, 2:    kv[$urandom_range(0, 9)] = ~kv[$urandom_range(0, 9)];
        3:       kv = 10'd0;
        default: kv = kv;
      endcase
      if ($urandom_range(0, 5) == 0) rdy = ~rdy;
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
